// File: rtl/sparc_ifu_dyser_arb.sv
// Shares the single DySER unit among the four threads of a core. It sequences
// init/send/recv/commit ops and drives per-thread stall, wake and fault pulses.
module sparc_ifu_dyser_arb #(
    parameter int                WDOG_W   = 8,
    parameter logic [WDOG_W-1:0] WDOG_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       se,
    input  logic       dyser_req_e,
    input  logic [1:0] dyser_op_e,
    input  logic [3:0] thr_e,
    input  logic [3:0] dtu_fcl_thr_active,
    input  logic [3:0] thr_kill,
    input  logic       dyser_done,
    output logic       dyser_start,
    output logic [1:0] dyser_start_op,
    output logic [3:0] dyser_owner,
    output logic [3:0] dyser_ifu_stallreq,
    output logic [3:0] dyser_wake,
    output logic [3:0] dyser_fault
);
    typedef enum logic [1:0] {IDLE, BUSY, OWNED, DRAIN} state_t;

    localparam logic [1:0] OP_INIT   = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b11;

    state_t            state_reg, state_next;
    logic [3:0]        owner_reg, owner_next;
    logic [3:0]        pend_reg, pend_next;
    logic [1:0]        rr_ptr_reg, rr_ptr_next;
    logic [WDOG_W-1:0] wdog_reg, wdog_next;
    logic              silent_reg, silent_next;
    logic              start_reg, start_next;
    logic [1:0]        start_op_reg, start_op_next;
    logic [3:0]        stall_reg, stall_next;
    logic [3:0]        wake_reg, wake_next;
    logic [3:0]        fault_reg, fault_next;

    logic       unused_se;
    logic [1:0] e_idx, pick_idx, rr_idx;
    logic       e_vld, e_init, e_own, e_active, owner_kill, timeout, pick_vld;
    logic [3:0] cand;
    logic       busy_next;

    assign unused_se = se;

    always_comb begin
        e_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (thr_e[i]) e_idx = 2'(i);
        end
    end

    // A killed thread's E request is dropped outright.
    assign e_vld      = dyser_req_e && |(thr_e & ~thr_kill);
    assign e_init     = e_vld && (dyser_op_e == OP_INIT);
    assign e_active   = |(thr_e & dtu_fcl_thr_active);
    // Once the owner is killed during drain it is no longer treated as owner.
    assign e_own      = e_vld && |(thr_e & owner_reg) && !silent_reg;
    assign owner_kill = |(owner_reg & thr_kill);
    assign timeout    = (wdog_reg == WDOG_MAX);
    assign cand       = pend_reg & dtu_fcl_thr_active & ~thr_kill;

    // Round-robin search starting one past the last grant.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr_reg;
        rr_idx   = rr_ptr_reg;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = rr_ptr_reg + 2'(i);
            if (!pick_vld && cand[rr_idx]) begin
                pick_vld = 1'b1;
                pick_idx = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_reg    <= IDLE;
            owner_reg    <= 4'b0000;
            pend_reg     <= 4'b0000;
            rr_ptr_reg   <= 2'd3;
            wdog_reg     <= '0;
            silent_reg   <= 1'b0;
            start_reg    <= 1'b0;
            start_op_reg <= 2'b00;
            stall_reg    <= 4'b0000;
            wake_reg     <= 4'b0000;
            fault_reg    <= 4'b0000;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            pend_reg     <= pend_next;
            rr_ptr_reg   <= rr_ptr_next;
            wdog_reg     <= wdog_next;
            silent_reg   <= silent_next;
            start_reg    <= start_next;
            start_op_reg <= start_op_next;
            stall_reg    <= stall_next;
            wake_reg     <= wake_next;
            fault_reg    <= fault_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        pend_next     = pend_reg & ~thr_kill;
        rr_ptr_next   = rr_ptr_reg;
        wdog_next     = wdog_reg;
        silent_next   = silent_reg;
        start_next    = 1'b0;
        start_op_next = OP_INIT;
        wake_next     = 4'b0000;
        fault_next    = 4'b0000;

        unique case (state_reg)
            IDLE: begin
                silent_next = 1'b0;
                if (pick_vld) begin
                    // Pending threads win over a fresh E init for fairness.
                    state_next          = BUSY;
                    owner_next          = 4'b0001 << pick_idx;
                    rr_ptr_next         = pick_idx;
                    pend_next[pick_idx] = 1'b0;
                    start_next          = 1'b1;
                    wdog_next           = '0;
                    if (e_init && (e_idx != pick_idx)) pend_next[e_idx] = 1'b1;
                end else if (e_init && e_active) begin
                    state_next  = BUSY;
                    owner_next  = 4'b0001 << e_idx;
                    rr_ptr_next = e_idx;
                    start_next  = 1'b1;
                    wdog_next   = '0;
                end else if (e_init) begin
                    pend_next[e_idx] = 1'b1;
                end
                if (e_vld && !e_init) fault_next = fault_next | thr_e;
            end
            BUSY: begin
                if (owner_kill) begin
                    if (dyser_done || timeout) begin
                        state_next = IDLE;
                        owner_next = 4'b0000;
                        wdog_next  = '0;
                    end else begin
                        state_next  = DRAIN;
                        silent_next = 1'b1;
                        wdog_next   = wdog_reg + 1'b1;
                    end
                end else if (dyser_done || timeout) begin
                    state_next = OWNED;
                    wake_next  = owner_reg;
                    wdog_next  = '0;
                    if (!dyser_done) fault_next = fault_next | owner_reg;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
                if (e_own) fault_next = fault_next | owner_reg;
            end
            OWNED: begin
                if (owner_kill) begin
                    state_next = IDLE;
                    owner_next = 4'b0000;
                end else if (e_own) begin
                    start_next    = 1'b1;
                    start_op_next = dyser_op_e;
                    wdog_next     = '0;
                    state_next    = (dyser_op_e == OP_COMMIT) ? DRAIN : BUSY;
                end
            end
            DRAIN: begin
                if (dyser_done || timeout) begin
                    if (!silent_reg && !owner_kill) begin
                        wake_next = owner_reg;
                        if (!dyser_done) fault_next = fault_next | owner_reg;
                    end
                    state_next  = IDLE;
                    owner_next  = 4'b0000;
                    silent_next = 1'b0;
                    wdog_next   = '0;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                    if (owner_kill) silent_next = 1'b1;
                end
                if (e_own) fault_next = fault_next | owner_reg;
            end
        endcase

        // Non-owner traffic while the unit is claimed: init queues, anything else faults.
        if ((state_reg != IDLE) && e_vld && !e_own) begin
            if (e_init) pend_next[e_idx] = 1'b1;
            else        fault_next = fault_next | thr_e;
        end
    end

    always_comb begin
        busy_next = ((state_next == BUSY) || (state_next == DRAIN)) && !silent_next;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stall
            assign stall_next[gi] = pend_next[gi] | (owner_next[gi] & busy_next);
        end
    endgenerate

    always @(posedge clk) begin
        if (rst_l && dyser_req_e) assert ($onehot(thr_e));
    end

    assign dyser_start        = start_reg;
    assign dyser_start_op     = start_op_reg;
    assign dyser_owner        = owner_reg;
    assign dyser_ifu_stallreq = stall_reg;
    assign dyser_wake         = wake_reg;
    assign dyser_fault        = fault_reg;
endmodule
